// File: rtl/tm1638_responder.sv
// tm1638_responder
//   Device-side model of the TM1638 STB/SCLK/DIO link. The three link
//   signals are oversampled on clk. The block decodes data, address and
//   display-control commands, keeps a 16-byte display RAM plus the
//   on/brightness state, and (optionally) returns key-scan bytes on DIO.
//
//   Optional feature macro: TM1638_RESP_KEYSCAN_EN
//     defined   : read commands shift KEY_BYTES bytes of keys out on DIO
//     undefined : read commands only set the mode; dio_out/dio_oe are 0
//
// Parameters
//   SYNC_STAGES  synchronizer depth on stb/sclk/dio_in (>= 2)
//   KEY_BYTES    key bytes returned per read command (1..4)
//
// Ports
//   clk, reset     local clock, asynchronous active-high reset
//   stb            host strobe, low = frame active
//   sclk           host serial clock, idles high
//   dio_in         serial data from host, LSB first
//   dio_out/dio_oe serial key data to host and its drive enable
//   keys           key matrix state, byte k = keys[8k+7:8k]
//   disp_ram       display RAM, byte i = disp_ram[8i+7:8i]
//   display_on     display-control bit 3
//   brightness     display-control bits 2:0
//   wr_strobe      one-clk pulse per RAM byte write (wr_addr/wr_data valid)
//   frame_err      one-clk pulse when stb rises with a partial byte pending
module tm1638_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int KEY_BYTES   = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stb,
    input  logic         sclk,
    input  logic         dio_in,
    output logic         dio_out,
    output logic         dio_oe,
    input  logic [31:0]  keys,
    output logic [127:0] disp_ram,
    output logic         display_on,
    output logic [2:0]   brightness,
    output logic         wr_strobe,
    output logic [3:0]   wr_addr,
    output logic [7:0]   wr_data,
    output logic         frame_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WDATA,
        S_KEYTX,
        S_SKIP
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] stb_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] dio_sync;
    logic                   stb_prev;
    logic                   sclk_prev;
    logic [2:0]             bit_cnt;
    logic [7:0]             shreg;
    logic [3:0]             addr;
    logic                   fixed_addr;
    logic                   read_mode;

    logic       stb_s, sclk_s, dio_s;
    logic       stb_rise, stb_fall, sclk_rise;
    logic       receiving, byte_done;
    logic [7:0] rx_byte;

    assign stb_s  = stb_sync[SYNC_STAGES-1];
    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign dio_s  = dio_sync[SYNC_STAGES-1];

    assign stb_rise  = stb_s & ~stb_prev;
    assign stb_fall  = ~stb_s & stb_prev;
    // sclk edges only count inside a frame
    assign sclk_rise = sclk_s & ~sclk_prev & ~stb_s;

    assign receiving = (state == S_CMD) || (state == S_WDATA) || (state == S_SKIP);
    assign byte_done = sclk_rise && receiving && (bit_cnt == 3'd7);
    // LSB first: new bit enters at the top, so after 8 bits bit 0 is the first one
    assign rx_byte   = {dio_s, shreg[7:1]};

    // read_mode is kept as architectural state but nothing downstream consumes it
    logic read_mode_unused;
    assign read_mode_unused = read_mode;

`ifdef TM1638_RESP_KEYSCAN_EN
    localparam logic [5:0] TX_BITS = 6'(KEY_BYTES * 8);

    logic        sclk_fall;
    logic [31:0] key_sh;
    logic [5:0]  tx_cnt;
    logic        dio_out_r;
    logic        dio_oe_r;

    assign sclk_fall = ~sclk_s & sclk_prev & ~stb_s;
    assign dio_out   = dio_out_r;
    assign dio_oe    = dio_oe_r;
`else
    logic keys_unused;
    assign keys_unused = ^keys;
    assign dio_out     = 1'b0;
    assign dio_oe      = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            stb_sync   <= '1;
            sclk_sync  <= '1;
            dio_sync   <= '0;
            stb_prev   <= 1'b1;
            sclk_prev  <= 1'b1;
            bit_cnt    <= '0;
            shreg      <= '0;
            addr       <= '0;
            fixed_addr <= 1'b0;
            read_mode  <= 1'b0;
            disp_ram   <= '0;
            display_on <= 1'b0;
            brightness <= '0;
            wr_strobe  <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_err  <= 1'b0;
`ifdef TM1638_RESP_KEYSCAN_EN
            key_sh     <= '0;
            tx_cnt     <= '0;
            dio_out_r  <= 1'b0;
            dio_oe_r   <= 1'b0;
`endif
        end else begin
            stb_sync  <= {stb_sync[SYNC_STAGES-2:0], stb};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            dio_sync  <= {dio_sync[SYNC_STAGES-2:0], dio_in};
            stb_prev  <= stb_s;
            sclk_prev <= sclk_s;
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;

            // stb rise outranks a byte completing in the same clk
            if (stb_rise) begin
                state     <= S_IDLE;
                bit_cnt   <= '0;
                frame_err <= (bit_cnt != 3'd0);
`ifdef TM1638_RESP_KEYSCAN_EN
                dio_oe_r  <= 1'b0;
                dio_out_r <= 1'b0;
`endif
            end else begin
                if (sclk_rise && receiving) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    shreg   <= rx_byte;
                end

                case (state)
                    S_IDLE: begin
                        if (stb_fall) begin
                            state   <= S_CMD;
                            bit_cnt <= '0;
                        end
                    end

                    S_CMD: begin
                        if (byte_done) begin
                            case (rx_byte[7:6])
                                2'b01: begin
                                    read_mode  <= rx_byte[1];
                                    fixed_addr <= rx_byte[2];
`ifdef TM1638_RESP_KEYSCAN_EN
                                    if (rx_byte[1]) begin
                                        state  <= S_KEYTX;
                                        key_sh <= keys;
                                        tx_cnt <= '0;
                                    end else begin
                                        state  <= S_SKIP;
                                    end
`else
                                    state      <= S_SKIP;
`endif
                                end
                                2'b11: begin
                                    addr  <= rx_byte[3:0];
                                    state <= S_WDATA;
                                end
                                2'b10: begin
                                    display_on <= rx_byte[3];
                                    brightness <= rx_byte[2:0];
                                    state      <= S_SKIP;
                                end
                                default: state <= S_SKIP;
                            endcase
                        end
                    end

                    S_WDATA: begin
                        if (byte_done) begin
                            disp_ram[{addr, 3'b000} +: 8] <= rx_byte;
                            wr_strobe <= 1'b1;
                            wr_addr   <= addr;
                            wr_data   <= rx_byte;
                            if (!fixed_addr) begin
                                addr <= addr + 4'd1;
                            end
                        end
                    end

                    S_KEYTX: begin
`ifdef TM1638_RESP_KEYSCAN_EN
                        if (sclk_fall) begin
                            if (tx_cnt != TX_BITS) begin
                                dio_oe_r  <= 1'b1;
                                dio_out_r <= key_sh[0];
                                key_sh    <= key_sh >> 1;
                                tx_cnt    <= tx_cnt + 6'd1;
                            end else begin
                                dio_oe_r  <= 1'b0;
                                dio_out_r <= 1'b0;
                            end
                        end
`else
                        state <= S_SKIP;
`endif
                    end

                    S_SKIP: ;

                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tm1638_responder.sv
// tb_tm1638_responder
//   Directed bench for tm1638_responder. A host model drives STB/SCLK/DIO;
//   each expected RAM write is queued when issued and a monitor pops the
//   queue on every wr_strobe pulse.
module tb_tm1638_responder;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         stb = 1'b1;
    logic         sclk = 1'b1;
    logic         dio_in = 1'b0;
    logic [31:0]  keys = '0;
    logic         dio_out;
    logic         dio_oe;
    logic [127:0] disp_ram;
    logic         display_on;
    logic [2:0]   brightness;
    logic         wr_strobe;
    logic [3:0]   wr_addr;
    logic [7:0]   wr_data;
    logic         frame_err;

    tm1638_responder #(
        .SYNC_STAGES(2),
        .KEY_BYTES(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .stb(stb),
        .sclk(sclk),
        .dio_in(dio_in),
        .dio_out(dio_out),
        .dio_oe(dio_oe),
        .keys(keys),
        .disp_ram(disp_ram),
        .display_on(display_on),
        .brightness(brightness),
        .wr_strobe(wr_strobe),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    int   n_checks = 0;
    int   n_fail = 0;
    int   err_pulses = 0;
    wr_t  exp_q[$];
    wr_t  mon_e;
    logic [7:0] model [16];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    function automatic logic [127:0] model_vec();
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[i*8 +: 8] = model[i];
        return v;
    endfunction

    // scoreboard monitor for RAM writes, plus frame_err pulse counter
    always @(negedge clk) begin
        if (!reset && wr_strobe) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: actual addr %h data %h required no write", wr_addr, wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 128'(wr_addr), 128'(mon_e.a));
                check("wr_data", 128'(wr_data), 128'(mon_e.d));
            end
        end
        if (!reset && frame_err) err_pulses++;
    end

    // half sclk period = 5 clk
    task automatic hp();
        repeat (5) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            sclk   = 1'b0;
            dio_in = b[i];
            hp();
            sclk   = 1'b1;
            hp();
        end
    endtask

    task automatic send(input logic [7:0] b);
        send_bits(b, 8);
    endtask

    task automatic open_frame();
        stb = 1'b0;
        hp();
    endtask

    task automatic close_frame();
        stb = 1'b1;
        hp();
        hp();
    endtask

    task automatic expect_wr(input logic [3:0] a, input logic [7:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
        model[a] = d;
    endtask

    task automatic cmd_frame(input logic [7:0] b);
        open_frame();
        send(b);
        close_frame();
    endtask

    logic [7:0]  digits [8];
    logic [7:0]  d;
    logic [31:0] got;
    int          err_base;

    initial begin
        digits = '{8'h5B, 8'h5B, 8'h06, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h7F};
        for (int i = 0; i < 16; i++) model[i] = 8'h00;

        // reset state
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_disp_ram", disp_ram, 128'h0);
        check("rst_ctrl", {display_on, brightness}, 4'h0);
        check("rst_dio", {dio_out, dio_oe}, 2'b00);
        check("rst_wr", {wr_strobe, wr_addr, wr_data}, 13'h0);
        check("rst_frame_err", frame_err, 1'b0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // full refresh
        cmd_frame(8'h40);
        open_frame();
        send(8'hC0);
        for (int i = 0; i < 16; i++) begin
            d = (i % 2 == 1) ? 8'h00 : digits[i/2];
            expect_wr(4'(i), d);
            send(d);
        end
        close_frame();
        cmd_frame(8'h8F);
        check("refresh_display_on", display_on, 1'b1);
        check("refresh_brightness", brightness, 3'd7);
        check("refresh_ram", disp_ram, model_vec());
        check("refresh_pending_writes", exp_q.size(), 0);

        // fixed address
        cmd_frame(8'h44);
        open_frame();
        send(8'hC3);
        expect_wr(4'd3, 8'hAA);
        send(8'hAA);
        expect_wr(4'd3, 8'h55);
        send(8'h55);
        close_frame();
        check("fixed_ram", disp_ram, model_vec());
        check("fixed_ram3", disp_ram[31:24], 8'h55);
        check("fixed_pending_writes", exp_q.size(), 0);

        // address wrap
        cmd_frame(8'h40);
        open_frame();
        send(8'hCF);
        expect_wr(4'd15, 8'h11);
        send(8'h11);
        expect_wr(4'd0, 8'h22);
        send(8'h22);
        close_frame();
        check("wrap_ram15", disp_ram[127:120], 8'h11);
        check("wrap_ram0", disp_ram[7:0], 8'h22);
        check("wrap_ram", disp_ram, model_vec());

        // key read
        keys = 32'h84210F5A;
        open_frame();
        send(8'h42);
        got = '0;
        for (int i = 0; i < 32; i++) begin
            sclk = 1'b0;
            hp();
`ifdef TM1638_RESP_KEYSCAN_EN
            got[i] = dio_out;
            if (i % 8 == 7) check("key_oe_driving", dio_oe, 1'b1);
`else
            if (i % 8 == 7) check("key_oe_disabled", {dio_oe, dio_out}, 2'b00);
`endif
            sclk = 1'b1;
            hp();
        end
`ifdef TM1638_RESP_KEYSCAN_EN
        check("key_byte0", got[7:0], 8'h5A);
        check("key_byte1", got[15:8], 8'h0F);
        check("key_byte2", got[23:16], 8'h21);
        check("key_byte3", got[31:24], 8'h84);
`endif
        sclk = 1'b0;
        hp();
        check("key_oe_after_last", dio_oe, 1'b0);
        sclk = 1'b1;
        hp();
        close_frame();
        check("key_oe_after_stb", dio_oe, 1'b0);
        check("key_no_writes", exp_q.size(), 0);

        // abort with partial byte
        err_base = err_pulses;
        open_frame();
        send(8'hC0);
        expect_wr(4'd0, 8'h12);
        send(8'h12);
        send_bits(8'hFF, 5);
        close_frame();
        check("abort_ram0", disp_ram[7:0], 8'h12);
        check("abort_ram", disp_ram, model_vec());
        check("abort_frame_err", err_pulses - err_base, 1);

        // display off
        cmd_frame(8'h80);
        check("off_ctrl", {display_on, brightness}, 4'h0);
        check("off_ram", disp_ram, model_vec());

        // reset mid-byte
        err_base = err_pulses;
        open_frame();
        send(8'hC0);
        send_bits(8'h33, 3);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_disp_ram", disp_ram, 128'h0);
        check("midrst_ctrl", {display_on, brightness}, 4'h0);
        check("midrst_dio", {dio_out, dio_oe}, 2'b00);
        check("midrst_wr", {wr_strobe, wr_addr, wr_data, frame_err}, 14'h0);
        stb  = 1'b1;
        sclk = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        repeat (10) @(negedge clk);
        check("postrst_ram", disp_ram, model_vec());
        check("postrst_no_err", err_pulses - err_base, 0);

        // reset does not clear addressability: a fresh write lands normally
        open_frame();
        send(8'hC7);
        expect_wr(4'd7, 8'h3C);
        send(8'h3C);
        close_frame();
        check("postrst_write", disp_ram, model_vec());
        check("final_pending_writes", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tm1638_responder.md
Name: tm1638_responder

Overview:
- Device-side (TM1638 chip end) model of the STB/SCLK/DIO serial link driven by the team's display controller.
- Oversamples the three link signals on the local clk and decodes data, address and display-control commands.
- Maintains a 16-byte display RAM plus display on/brightness state.
- Returns key-scan bytes on DIO for read commands.
- Used as a synthesizable bus-functional responder for board loopback and simulation of the controller.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on stb/sclk/dio_in (min 2).
- KEY_BYTES, 4, key bytes returned per read command (1..4).

Ports:
- clk  in  1  local oversampling clock; sclk half-period ≥ SYNC_STAGES+1 clk cycles.
- reset  in  1  asynchronous, active-high.
- stb  in  1  strobe from host; low = frame active.
- sclk  in  1  serial clock from host; idles high.
- dio_in  in  1  serial data from host.
- dio_out  out  1  serial data to host (key bytes).
- dio_oe  out  1  high while responder drives DIO.
- keys  in  32  key matrix state; byte k = keys[8k+7:8k].
- disp_ram  out  128  display RAM; byte i at [8i+7:8i].
- display_on  out  1  display-control bit3.
- brightness  out  3  display-control bits[2:0].
- wr_strobe  out  1  one-clk pulse per RAM byte write.
- wr_addr  out  4  address of current write.
- wr_data  out  8  data of current write.
- frame_err  out  1  one-clk pulse when STB rises with a partial byte pending.

Behaviour:
- Reset values (all outputs and state):
  - disp_ram = 0; display_on = 0; brightness = 0.
  - dio_out = 0; dio_oe = 0; wr_strobe = 0; wr_addr = 0; wr_data = 0; frame_err = 0.
  - Internal: mode = write / auto-increment; addr = 0; state = IDLE.
- Reset mid-frame aborts immediately with no partial write.
- Synchronizers and edge detection:
  - stb, sclk and dio_in each pass through SYNC_STAGES flops.
  - Edges are detected on the synchronized values.
- Bit reception:
  - LSB first.
  - DIO is sampled on the synchronized sclk rising edge while stb is low.
  - A 3-bit counter assembles bytes; a byte completes on the 8th rising edge.
- States:
  - IDLE: stb high. Falling stb → CMD, with the bit counter cleared.
  - CMD: the first complete byte is decoded on bits[7:6]:
    - 01, data command: bit1 = read(1)/write(0), bit2 = fixed(1)/auto-inc(0); bit3 ignored. Mode persists across frames. Read → KEYTX, write → SKIP.
    - 11, address command: addr = bits[3:0] → WDATA.
    - 10, display control: display_on = bit3, brightness = bits[2:0] → SKIP.
    - 00: → SKIP.
  - WDATA: each complete byte is written as follows.
    - ram[addr] = byte; wr_strobe pulses the same clk as the write, with wr_addr/wr_data valid.
    - If auto-inc, addr = addr+1 mod 16 (15 wraps to 0); if fixed, addr is unchanged.
    - Writes proceed regardless of read mode.
  - KEYTX:
    - keys is snapshotted on the clk the read command byte completes.
    - On each synchronized sclk falling edge, dio_oe = 1 and dio_out = next bit: byte0 LSB first, then byte1, and so on.
    - After KEY_BYTES*8 bits, dio_oe = 0 on the next falling edge.
    - Incoming DIO is ignored.
  - SKIP: further bytes are ignored until stb rises.
- STB rising in any state:
  - → IDLE; dio_oe = 0 on the same clk.
  - A partial byte (counter ≠ 0) is discarded and frame_err pulses.
  - addr is retained.
- Simultaneous stb rise and 8th sclk rise within one clk: stb rise takes priority and the byte is discarded.
- Latency: the RAM write appears 1 clk after the synchronized edge that completes the byte, i.e. SYNC_STAGES+1 clk after the raw sclk edge.

Optional Feature:
- Macro: TM1638_RESP_KEYSCAN_EN.
- Defined: KEYTX is implemented as above.
- Undefined:
  - A read data command still sets mode and goes → SKIP.
  - dio_oe is constant 0 and dio_out is constant 0.
  - The keys input is unused.

Test Plan:
- Full refresh: frame 0x40; frame 0xC0 followed by 16 bytes 0x5B,0x00,0x5B,0x00,0x06,…,0x7F,0x00; frame 0x8F → disp_ram bytes even = digits, odd = 0x00; 16 wr_strobe pulses on addr 0..15; display_on = 1; brightness = 7.
- Fixed address: frames 0x44, then 0xC3,0xAA,0x55 → ram[3] = 0x55, all other bytes unchanged, 2 wr_strobe pulses both with wr_addr = 3.
- Wrap: frames 0x40, then 0xCF,0x11,0x22 → ram[15] = 0x11, ram[0] = 0x22.
- Key read (macro defined): keys = 0x84210F5A, frame 0x42 followed by 32 sclk cycles → host samples 0x5A,0x0F,0x21,0x84 on rising edges; dio_oe low after the last bit and after stb rises. Macro undefined → dio_oe stays 0 throughout.
- Abort: frame 0xC0, 0x12, then stb rises after 5 bits of a second byte → ram[0] = 0x12, ram[1] unchanged, frame_err pulses once. Reset asserted mid-byte → all outputs return to reset values.
- Display off: frame 0x80 → display_on = 0, brightness = 0, disp_ram unchanged.
